// File: rtl/bus_timer_responder_pkg.sv
// Shared constants for the bus timer responder: register map,
// control/status bit positions and the window decode width.
package bus_timer_responder_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_RELOAD = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_off_t;

    localparam int CTRL_W = 4;
    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;
    localparam int CTRL_AUTO = 2;
    localparam int CTRL_ISEL = 3;

    localparam int STATUS_EXPIRED = 0;

    // Address bits below this index select a register inside the window.
    localparam int DEC_LSB = 3;

    function automatic logic [15:0] lane_merge(
        input logic [15:0] old,
        input logic [15:0] din,
        input logic        lo,
        input logic        hi
    );
        lane_merge = {hi ? din[15:8] : old[15:8],
                      lo ? din[7:0]  : old[7:0]};
    endfunction

endpackage

// File: rtl/bus_timer_responder_strobe.sv
// Registers one active-low bus strobe and flags its falling edge.
// Reset treats the strobe as already low so a held access is not replayed.
module bus_strobe_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic strobe_n,
    output logic fall
);

    logic prev_n;

    always_ff @(posedge CLK) begin
        if (RESET) prev_n <= 1'b0;
        else prev_n <= strobe_n;
    end

    assign fall = prev_n & ~strobe_n;

endmodule

// File: rtl/bus_timer_responder.sv
// Memory-mapped 16-bit down-counter timer responding to RDN/WRN0/WRN1,
// with prescaler, auto-reload and routable level interrupt.
module bus_timer_responder
    import bus_timer_responder_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          PRESCALE  = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ADDR,
    input  logic [15:0] DIN,
    input  logic        RDN,
    input  logic        WRN0,
    input  logic        WRN1,
    output logic [15:0] DOUT,
    output logic        DOUT_OEN,
    output logic        INT0,
    output logic        INT1
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic rd_fall, wr0_fall, wr1_fall;

    bus_strobe_edge u_rd  (.CLK(CLK), .RESET(RESET), .strobe_n(RDN),  .fall(rd_fall));
    bus_strobe_edge u_wr0 (.CLK(CLK), .RESET(RESET), .strobe_n(WRN0), .fall(wr0_fall));
    bus_strobe_edge u_wr1 (.CLK(CLK), .RESET(RESET), .strobe_n(WRN1), .fall(wr1_fall));

    logic              hit;
    reg_off_t          off;
    logic              wr_lo, wr_hi;
    logic              unused_addr;

    assign hit = (ADDR[15:DEC_LSB] == BASE_ADDR[15:DEC_LSB]);
    assign off = reg_off_t'(ADDR[2:1]);
    assign wr_lo = wr0_fall & hit;
    assign wr_hi = wr1_fall & hit;
    assign unused_addr = ADDR[0];

    logic [CTRL_W-1:0] ctrl_q, ctrl_n;
    logic [15:0]       reload_q, reload_n;
    logic [15:0]       count_q, count_n;
    logic              expired_q, expired_n;
    logic [PW-1:0]     presc_q, presc_n;
    logic [15:0]       dout_q;
    logic              oen_q;

    logic ctrl_wr, reload_wr, count_wr, status_wr;
    logic en, tick, tick_eff, expire, en_rise;
    logic [15:0] rdata;

    always_comb begin
        ctrl_wr = 1'b0;
        reload_wr = 1'b0;
        count_wr = 1'b0;
        status_wr = 1'b0;
        if (wr_lo || wr_hi) begin
            unique case (off)
                REG_CTRL:   ctrl_wr = 1'b1;
                REG_RELOAD: reload_wr = 1'b1;
                REG_COUNT:  count_wr = 1'b1;
                REG_STATUS: status_wr = 1'b1;
            endcase
        end
    end

    assign en = ctrl_q[CTRL_EN];
    assign tick = en & (presc_q == PMAX);
    // A COUNT write in the same cycle swallows the tick entirely.
    assign tick_eff = tick & ~count_wr;
    assign expire = tick_eff & (count_q == 16'd0);
    assign en_rise = ctrl_wr & wr_lo & DIN[CTRL_EN] & ~en;

    always_comb begin
        ctrl_n = ctrl_q;
        presc_n = presc_q;
        count_n = count_q;
        reload_n = reload_q;
        expired_n = expired_q;

        if (en) presc_n = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
        if (en_rise) presc_n = '0;

        if (tick_eff) begin
            if (count_q != 16'd0) count_n = count_q - 1'b1;
            else if (ctrl_q[CTRL_AUTO]) count_n = reload_q;
        end
        if (expire && !ctrl_q[CTRL_AUTO]) ctrl_n[CTRL_EN] = 1'b0;

        if (ctrl_wr && wr_lo) ctrl_n = DIN[CTRL_W-1:0];
        if (reload_wr) reload_n = lane_merge(reload_q, DIN, wr_lo, wr_hi);
        if (count_wr) count_n = lane_merge(count_q, DIN, wr_lo, wr_hi);

        // Expiry outranks a same-cycle clear so no event is lost.
        if (status_wr && wr_lo && DIN[STATUS_EXPIRED]) expired_n = 1'b0;
        if (expire) expired_n = 1'b1;
    end

    always_comb begin
        rdata = '0;
        unique case (off)
            REG_CTRL:   rdata = {{(16 - CTRL_W){1'b0}}, ctrl_q};
            REG_RELOAD: rdata = reload_q;
            REG_COUNT:  rdata = count_q;
            REG_STATUS: rdata = {15'd0, expired_q};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q <= '0;
            reload_q <= '0;
            count_q <= '0;
            expired_q <= 1'b0;
            presc_q <= '0;
            dout_q <= '0;
            oen_q <= 1'b1;
        end else begin
            ctrl_q <= ctrl_n;
            reload_q <= reload_n;
            count_q <= count_n;
            expired_q <= expired_n;
            presc_q <= presc_n;
            if (rd_fall && hit) begin
                dout_q <= rdata;
                oen_q <= 1'b0;
            end else if (RDN) begin
                oen_q <= 1'b1;
            end
        end
    end

    assign DOUT = dout_q;
    assign DOUT_OEN = oen_q;
    assign INT0 = expired_q & ctrl_q[CTRL_IE] & ~ctrl_q[CTRL_ISEL];
    assign INT1 = expired_q & ctrl_q[CTRL_IE] & ctrl_q[CTRL_ISEL];

endmodule

// File: tb/tb_bus_timer_responder.sv
// Self-checking bench for bus_timer_responder: scenario tasks against
// expiry times and register contents computed from the timer rules.
module tb_bus_timer_responder;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam int P = 4;
    localparam logic [15:0] A_CTRL = 16'hFF00;
    localparam logic [15:0] A_RELOAD = 16'hFF02;
    localparam logic [15:0] A_COUNT = 16'hFF04;
    localparam logic [15:0] A_STATUS = 16'hFF06;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] ADDR = '0;
    logic [15:0] DIN = '0;
    logic        RDN = 1'b1;
    logic        WRN0 = 1'b1;
    logic        WRN1 = 1'b1;
    logic [15:0] DOUT;
    logic        DOUT_OEN;
    logic        INT0;
    logic        INT1;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    bus_timer_responder #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN),
        .RDN(RDN), .WRN0(WRN0), .WRN1(WRN1), .DOUT(DOUT),
        .DOUT_OEN(DOUT_OEN), .INT0(INT0), .INT1(INT1)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    // The write acts on the edge following the call: cyc+1.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d,
                             input bit lo, input bit hi);
        ADDR = a;
        DIN = d;
        WRN0 = !lo;
        WRN1 = !hi;
        step();
        WRN0 = 1'b1;
        WRN1 = 1'b1;
        step();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d,
                            output logic oen_low, output logic oen_back);
        ADDR = a;
        RDN = 1'b0;
        step();
        oen_low = DOUT_OEN;
        d = DOUT;
        RDN = 1'b1;
        step();
        oen_back = DOUT_OEN;
    endtask

    task automatic wait_int(input bit sel, output int t);
        t = -1;
        for (int i = 0; i < 400; i++) begin
            if ((sel ? INT1 : INT0) === 1'b1) begin
                t = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic stop_clear();
        bus_write(A_CTRL, 16'h0000, 1, 1);
        bus_write(A_STATUS, 16'h0001, 1, 1);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic ol, ob;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_checks++;
        if (DOUT !== 16'h0 || DOUT_OEN !== 1'b1) begin
            n_err++;
            $display("FAIL reset_out: dout=%h oen=%b required 0000/1", DOUT, DOUT_OEN);
        end
        n_checks++;
        if (INT0 !== 1'b0 || INT1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_int: int0=%b int1=%b required 0/0", INT0, INT1);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + 16'(2 * i), d, ol, ob);
            n_checks++;
            if (d !== 16'h0 || ol !== 1'b0 || ob !== 1'b1) begin
                n_err++;
                $display("FAIL reset_reg%0d: data=%h oen=%b/%b required 0000 0/1",
                         i, d, ol, ob);
            end
        end
    endtask

    task automatic test_periodic();
        logic [15:0] d;
        logic ol, ob;
        int wc, t, t2;
        bus_write(A_RELOAD, 16'd3, 1, 1);
        bus_write(A_COUNT, 16'd3, 1, 1);
        wc = cyc + 1;
        bus_write(A_CTRL, 16'h0007, 1, 1);
        wait_int(0, t);
        n_checks++;
        if (t !== wc + 16 || INT1 !== 1'b0) begin
            n_err++;
            $display("FAIL periodic_first: cycle %0d int1=%b required %0d 0", t, INT1, wc + 16);
        end
        bus_read(A_COUNT, d, ol, ob);
        n_checks++;
        if (d !== 16'd3) begin
            n_err++;
            $display("FAIL periodic_reload: count=%h required 0003", d);
        end
        bus_write(A_STATUS, 16'h0001, 1, 1);
        n_checks++;
        if (INT0 !== 1'b0) begin
            n_err++;
            $display("FAIL periodic_w1c: int0=%b required 0", INT0);
        end
        wait_int(0, t2);
        n_checks++;
        if (t2 !== t + 16) begin
            n_err++;
            $display("FAIL periodic_second: cycle %0d required %0d", t2, t + 16);
        end
    endtask

    task automatic test_periodic_random();
        int c, r, wc, t, t2;
        bit isel;
        for (int k = 0; k < 5; k++) begin
            c = $urandom_range(0, 6);
            r = $urandom_range(0, 6);
            isel = 1'($urandom_range(0, 1));
            stop_clear();
            bus_write(A_RELOAD, 16'(r), 1, 1);
            bus_write(A_COUNT, 16'(c), 1, 1);
            wc = cyc + 1;
            bus_write(A_CTRL, {12'd0, isel, 3'b111}, 1, 1);
            wait_int(isel, t);
            n_checks++;
            if (t !== wc + (c + 1) * P || (isel ? INT0 : INT1) !== 1'b0) begin
                n_err++;
                $display("FAIL rand_first%0d: cycle %0d required %0d (c=%0d isel=%0d)",
                         k, t, wc + (c + 1) * P, c, isel);
            end
            bus_write(A_STATUS, 16'h0001, 1, 0);
            n_checks++;
            if (INT0 !== 1'b0 || INT1 !== 1'b0) begin
                n_err++;
                $display("FAIL rand_clear%0d: int0=%b int1=%b required 0/0", k, INT0, INT1);
            end
            wait_int(isel, t2);
            n_checks++;
            if (t2 !== t + (r + 1) * P) begin
                n_err++;
                $display("FAIL rand_period%0d: cycle %0d required %0d (r=%0d)",
                         k, t2, t + (r + 1) * P, r);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic [15:0] d, v;
        logic [15:0] m [4];
        logic ol, ob;
        bit lo, hi;
        int o;
        stop_clear();
        bus_write(A_RELOAD, 16'h1234, 1, 1);
        bus_write(A_RELOAD, 16'hABCD, 0, 1);
        bus_read(A_RELOAD, d, ol, ob);
        n_checks++;
        if (d !== 16'hAB34) begin
            n_err++;
            $display("FAIL lane_hi: reload=%h required ab34", d);
        end
        bus_write(A_RELOAD, 16'h1234, 1, 1);
        bus_write(A_RELOAD, 16'hABCD, 1, 0);
        bus_read(A_RELOAD, d, ol, ob);
        n_checks++;
        if (d !== 16'h12CD) begin
            n_err++;
            $display("FAIL lane_lo: reload=%h required 12cd", d);
        end
        m[0] = 16'h0;
        m[1] = 16'h12CD;
        m[2] = $urandom;
        m[3] = 16'h0;
        bus_write(A_COUNT, m[2], 1, 1);
        for (int k = 0; k < 16; k++) begin
            o = $urandom_range(0, 3);
            v = $urandom;
            if (o == 0) v[0] = 1'b0;
            lo = 1'($urandom_range(0, 1));
            hi = lo ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_write(BASE + 16'(2 * o), v, lo, hi);
            if (o == 0 && lo) m[0] = {12'd0, v[3:0]};
            if (o == 1 || o == 2) begin
                if (lo) m[o][7:0] = v[7:0];
                if (hi) m[o][15:8] = v[15:8];
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + 16'(2 * i), d, ol, ob);
            n_checks++;
            if (d !== m[i]) begin
                n_err++;
                $display("FAIL lane_rand_reg%0d: data=%h required %h", i, d, m[i]);
            end
        end
        bus_write(A_CTRL, 16'h0000, 1, 1);
    endtask

    task automatic test_one_shot();
        logic [15:0] d;
        logic ol, ob;
        int wc, t;
        stop_clear();
        bus_write(A_COUNT, 16'd1, 1, 1);
        wc = cyc + 1;
        bus_write(A_CTRL, 16'h000B, 1, 1);
        wait_int(1, t);
        n_checks++;
        if (t !== wc + 8 || INT0 !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_int1: cycle %0d int0=%b required %0d 0", t, INT0, wc + 8);
        end
        bus_read(A_CTRL, d, ol, ob);
        n_checks++;
        if (d !== 16'h000A) begin
            n_err++;
            $display("FAIL oneshot_ctrl: ctrl=%h required 000a", d);
        end
        repeat (20) step();
        bus_read(A_COUNT, d, ol, ob);
        n_checks++;
        if (d !== 16'h0 || INT1 !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_hold: count=%h int1=%b required 0000 1", d, INT1);
        end
    endtask

    task automatic test_collisions();
        logic [15:0] d;
        logic ol, ob;
        int wc;
        stop_clear();
        bus_write(A_RELOAD, 16'd7, 1, 1);
        bus_write(A_COUNT, 16'd1, 1, 1);
        wc = cyc + 1;
        bus_write(A_CTRL, 16'h0007, 1, 1);
        wait_to(wc + 7);
        bus_write(A_STATUS, 16'h0001, 1, 1);
        bus_read(A_STATUS, d, ol, ob);
        n_checks++;
        if (d !== 16'h0001 || INT0 !== 1'b1) begin
            n_err++;
            $display("FAIL coll_w1c: status=%h int0=%b required 0001 1", d, INT0);
        end
        wait_to(wc + 19);
        bus_write(A_COUNT, 16'd5, 1, 1);
        bus_read(A_COUNT, d, ol, ob);
        n_checks++;
        if (d !== 16'd5) begin
            n_err++;
            $display("FAIL coll_count: count=%h required 0005", d);
        end
    endtask

    task automatic test_strobe_decode();
        logic [15:0] d;
        logic ol, ob;
        int wc;
        stop_clear();
        bus_write(A_RELOAD, 16'h0011, 1, 1);
        bus_write(A_COUNT, 16'd100, 1, 1);
        wc = cyc + 1;
        bus_write(A_CTRL, 16'h0001, 1, 1);
        wait_to(wc + 2);
        ADDR = A_COUNT;
        DIN = 16'd5;
        WRN0 = 1'b0;
        repeat (3) step();
        WRN0 = 1'b1;
        step();
        bus_read(A_COUNT, d, ol, ob);
        n_checks++;
        if (d !== 16'd4) begin
            n_err++;
            $display("FAIL held_strobe: count=%h required 0004", d);
        end
        bus_read(16'hFE00, d, ol, ob);
        n_checks++;
        if (ol !== 1'b1 || d !== 16'd4) begin
            n_err++;
            $display("FAIL outside_read: oen=%b dout=%h required 1 0004", ol, d);
        end
        bus_write(16'hFE02, 16'h5A5A, 1, 1);
        bus_read(A_RELOAD, d, ol, ob);
        n_checks++;
        if (d !== 16'h0011) begin
            n_err++;
            $display("FAIL outside_write: reload=%h required 0011", d);
        end
    endtask

    task automatic test_reset_midcount();
        logic [15:0] d;
        logic ol, ob;
        bus_write(A_COUNT, 16'h0200, 1, 1);
        bus_write(A_CTRL, 16'h0007, 1, 1);
        repeat (5) step();
        ADDR = A_COUNT;
        RDN = 1'b0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_checks++;
        if (DOUT !== 16'h0 || DOUT_OEN !== 1'b1 || INT0 !== 1'b0 || INT1 !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_out: dout=%h oen=%b int=%b%b required 0000 1 00",
                     DOUT, DOUT_OEN, INT1, INT0);
        end
        step();
        n_checks++;
        if (DOUT_OEN !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_abort: oen=%b required 1", DOUT_OEN);
        end
        RDN = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + 16'(2 * i), d, ol, ob);
            n_checks++;
            if (d !== 16'h0) begin
                n_err++;
                $display("FAIL midreset_reg%0d: data=%h required 0000", i, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_periodic_random();
        test_byte_lanes();
        test_one_shot();
        test_collisions();
        test_strobe_decode();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
